// File: rtl/vga_pkg.sv
// Shared timing constants, axis-state encoding and the registered pixel payload.
package vga_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  // One pixel's worth of timing outputs, captured together so they stay aligned.
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             active;
    logic             frame_start;
    logic             line_start;
  } vga_pix_t;

  localparam vga_pix_t PIX_IDLE = '{
    hsync:       1'b1,
    vsync:       1'b1,
    x:           '0,
    y:           '0,
    active:      1'b0,
    frame_start: 1'b0,
    line_start:  1'b0
  };

  // Last segment-counter value of a given state.
  function automatic logic [CNT_W-1:0] seg_last(input axis_state_e st,
                                                input int unsigned len_active,
                                                input int unsigned len_front,
                                                input int unsigned len_sync,
                                                input int unsigned len_back);
    case (st)
      ST_ACTIVE: seg_last = CNT_W'(len_active - 1);
      ST_FRONT:  seg_last = CNT_W'(len_front - 1);
      ST_SYNC:   seg_last = CNT_W'(len_sync - 1);
      default:   seg_last = CNT_W'(len_back - 1);
    endcase
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-enable input and video timing outputs of the generator.
interface vga_if;
  import vga_pkg::*;

  logic             i_pix_en;
  logic             o_hSync;
  logic             o_vSync;
  logic [CNT_W-1:0] o_display_x_pos;
  logic [CNT_W-1:0] o_display_y_pos;
  logic             o_active;
  logic             o_frame_start;
  logic             o_line_start;

  modport master (
    input  i_pix_en,
    output o_hSync, o_vSync, o_display_x_pos, o_display_y_pos,
           o_active, o_frame_start, o_line_start
  );

  modport slave (
    output i_pix_en,
    input  o_hSync, o_vSync, o_display_x_pos, o_display_y_pos,
           o_active, o_frame_start, o_line_start
  );
endinterface

// File: rtl/vga_axis_timer.sv
// One timing axis: ACTIVE -> FRONT -> SYNC -> BACK segment FSM plus position counter.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int unsigned LEN_ACTIVE = 1,
  parameter int unsigned LEN_FRONT  = 1,
  parameter int unsigned LEN_SYNC   = 1,
  parameter int unsigned LEN_BACK   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output axis_state_e      state,
  output logic [CNT_W-1:0] pos
);

  axis_state_e      state_next;
  logic [CNT_W-1:0] seg;
  logic [CNT_W-1:0] seg_next;
  logic [CNT_W-1:0] pos_next;
  logic             seg_done;

  assign seg_done = (seg == seg_last(state, LEN_ACTIVE, LEN_FRONT, LEN_SYNC, LEN_BACK));

  // State, segment and position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACTIVE;
      seg   <= '0;
      pos   <= '0;
    end else begin
      state <= state_next;
      seg   <= seg_next;
      pos   <= pos_next;
    end
  end

  // Advance to the following segment once the current one has run its length.
  always_comb begin
    state_next = state;
    if (step && seg_done) begin
      unique case (state)
        ST_ACTIVE: state_next = ST_FRONT;
        ST_FRONT:  state_next = ST_SYNC;
        ST_SYNC:   state_next = ST_BACK;
        ST_BACK:   state_next = ST_ACTIVE;
      endcase
    end
  end

  // Segment counter restarts per state; position wraps at the end of BACK.
  always_comb begin
    seg_next = seg;
    pos_next = pos;
    if (step) begin
      seg_next = seg_done ? '0 : seg + CNT_W'(1);
      pos_next = (seg_done && state == ST_BACK) ? '0 : pos + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/position generator: two axis timers feeding one aligned output register.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF
) (
  input  logic  i_CLK,
  input  logic  i_RST,
  vga_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Positions are 10 bits wide, so a total beyond 1024 cannot be represented.
  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
  end

  axis_state_e      h_state;
  axis_state_e      v_state;
  logic [CNT_W-1:0] h_pos;
  logic [CNT_W-1:0] v_pos;
  logic             h_wrap_c;
  vga_pix_t         pix_d;
  vga_pix_t         pix_q;

  // Line ends on the enabled cycle where x leaves its last value.
  assign h_wrap_c = vga.i_pix_en && (h_pos == CNT_W'(H_TOTAL - 1));

  vga_axis_timer #(
    .LEN_ACTIVE (H_ACTIVE),
    .LEN_FRONT  (H_FRONT),
    .LEN_SYNC   (H_SYNC),
    .LEN_BACK   (H_BACK)
  ) u_h_timer (
    .clk   (i_CLK),
    .rst   (i_RST),
    .step  (vga.i_pix_en),
    .state (h_state),
    .pos   (h_pos)
  );

  vga_axis_timer #(
    .LEN_ACTIVE (V_ACTIVE),
    .LEN_FRONT  (V_FRONT),
    .LEN_SYNC   (V_SYNC),
    .LEN_BACK   (V_BACK)
  ) u_v_timer (
    .clk   (i_CLK),
    .rst   (i_RST),
    .step  (h_wrap_c),
    .state (v_state),
    .pos   (v_pos)
  );

  // Decode everything about the pixel the counters currently point at.
  always_comb begin
    pix_d             = PIX_IDLE;
    pix_d.hsync       = (h_state != ST_SYNC);
    pix_d.vsync       = (v_state != ST_SYNC);
    pix_d.x           = h_pos;
    pix_d.y           = v_pos;
    pix_d.active      = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
    pix_d.line_start  = (h_pos == '0);
    pix_d.frame_start = (h_pos == '0) && (v_pos == '0);
  end

  // Output register: updates only on enabled cycles so all fields stay aligned.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pix_q <= PIX_IDLE;
    end else if (vga.i_pix_en) begin
      pix_q <= pix_d;
    end
  end

  assign vga.o_hSync         = pix_q.hsync;
  assign vga.o_vSync         = pix_q.vsync;
  assign vga.o_display_x_pos = pix_q.x;
  assign vga.o_display_y_pos = pix_q.y;
  assign vga.o_active        = pix_q.active;
  assign vga.o_frame_start   = pix_q.frame_start;
  assign vga.o_line_start    = pix_q.line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line checks, small-timing instance for frame checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  vga_if vif ();
  vga_if vif_s ();

  vga_timing_gen dut (
    .i_CLK (clk),
    .i_RST (rst),
    .vga   (vif)
  );

  // Small frame: H 8/2/3/2 (total 15, hsync x=10..12), V 4/1/2/2 (total 9, vsync y=5..6).
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2)
  ) dut_s (
    .i_CLK (clk),
    .i_RST (rst),
    .vga   (vif_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic v);
    vif.i_pix_en   = v;
    vif_s.i_pix_en = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int hs_low, vs_low, first_x, first_y, ls_cnt, fs_cnt, act_cnt, period;
  int exp_x, exp_y;
  logic prev_fs, reached;

  initial begin
    rst = 1'b1;
    set_en(1'b0);
    tick();
    tick();

    // Reset state, default instance
    chk("rst_x",  32'(vif.o_display_x_pos), 0);
    chk("rst_y",  32'(vif.o_display_y_pos), 0);
    chk("rst_hs", 32'(vif.o_hSync), 1);
    chk("rst_vs", 32'(vif.o_vSync), 1);
    chk("rst_act", 32'(vif.o_active), 0);
    chk("rst_fs", 32'(vif.o_frame_start), 0);
    chk("rst_ls", 32'(vif.o_line_start), 0);

    // First enabled cycle presents the origin
    rst = 1'b0;
    set_en(1'b1);
    tick();
    chk("c0_x",  32'(vif.o_display_x_pos), 0);
    chk("c0_y",  32'(vif.o_display_y_pos), 0);
    chk("c0_act", 32'(vif.o_active), 1);
    chk("c0_fs", 32'(vif.o_frame_start), 1);
    chk("c0_ls", 32'(vif.o_line_start), 1);

    // One full default line
    hs_low = 0; first_x = -1; ls_cnt = 0; act_cnt = 0;
    for (int c = 1; c < 800; c++) begin
      tick();
      if (!vif.o_hSync) begin
        if (hs_low == 0) first_x = int'(vif.o_display_x_pos);
        hs_low++;
      end
      if (vif.o_line_start) ls_cnt++;
      if (vif.o_active) act_cnt++;
    end
    chk("line_last_x", 32'(vif.o_display_x_pos), 799);
    chk("hs_low_cnt", 32'(hs_low), 96);
    chk("hs_first_x", 32'(first_x), 656);
    chk("ls_in_line", 32'(ls_cnt), 0);
    chk("act_in_line", 32'(act_cnt), 639);
    tick();
    chk("c800_x",  32'(vif.o_display_x_pos), 0);
    chk("c800_y",  32'(vif.o_display_y_pos), 1);
    chk("c800_ls", 32'(vif.o_line_start), 1);
    chk("c800_fs", 32'(vif.o_frame_start), 0);

    // Disabled cycles hold every output
    set_en(1'b0);
    tick(); tick(); tick();
    chk("hold_x",  32'(vif.o_display_x_pos), 0);
    chk("hold_ls", 32'(vif.o_line_start), 1);
    chk("hold_hs", 32'(vif.o_hSync), 1);
    set_en(1'b1);
    tick();
    chk("resume_x",  32'(vif.o_display_x_pos), 1);
    chk("resume_ls", 32'(vif.o_line_start), 0);

    // Reset with enable low takes effect immediately (small instance mid-run)
    rst = 1'b1;
    set_en(1'b0);
    tick();
    chk("s_rst_x",  32'(vif_s.o_display_x_pos), 0);
    chk("s_rst_y",  32'(vif_s.o_display_y_pos), 0);
    chk("s_rst_hs", 32'(vif_s.o_hSync), 1);
    chk("s_rst_vs", 32'(vif_s.o_vSync), 1);
    chk("s_rst_act", 32'(vif_s.o_active), 0);
    chk("s_rst_fs", 32'(vif_s.o_frame_start), 0);
    chk("s_rst_ls", 32'(vif_s.o_line_start), 0);

    rst = 1'b0;
    set_en(1'b1);
    tick();
    chk("s_c0_fs", 32'(vif_s.o_frame_start), 1);
    chk("s_c0_act", 32'(vif_s.o_active), 1);

    // One full small frame (135 cycles)
    hs_low = 0; vs_low = 0; fs_cnt = 0; act_cnt = 0; first_x = -1; first_y = -1;
    for (int c = 0; c < 135; c++) begin
      if (c > 0) tick();
      if (!vif_s.o_hSync) hs_low++;
      if (!vif_s.o_vSync) begin
        if (vs_low == 0) begin
          first_x = int'(vif_s.o_display_x_pos);
          first_y = int'(vif_s.o_display_y_pos);
        end
        vs_low++;
      end
      if (vif_s.o_frame_start) fs_cnt++;
      if (vif_s.o_active) act_cnt++;
    end
    chk("s_last_x", 32'(vif_s.o_display_x_pos), 14);
    chk("s_last_y", 32'(vif_s.o_display_y_pos), 8);
    chk("s_fs_cnt", 32'(fs_cnt), 1);
    chk("s_vs_low", 32'(vs_low), 30);
    chk("s_vs_x", 32'(first_x), 0);
    chk("s_vs_y", 32'(first_y), 5);
    chk("s_hs_low", 32'(hs_low), 27);
    chk("s_act_cnt", 32'(act_cnt), 32);
    tick();
    chk("s_wrap_x",  32'(vif_s.o_display_x_pos), 0);
    chk("s_wrap_y",  32'(vif_s.o_display_y_pos), 0);
    chk("s_wrap_fs", 32'(vif_s.o_frame_start), 1);

    // Alternating enable doubles the frame period; outputs track enabled cycles only
    exp_x = 0; exp_y = 0; period = 0; prev_fs = 1'b1;
    for (int t = 1; t <= 300 && period == 0; t++) begin
      set_en((t % 2) == 0);
      tick();
      if ((t % 2) == 0) begin
        if (exp_x == 14) begin
          exp_x = 0;
          exp_y = (exp_y == 8) ? 0 : exp_y + 1;
        end else begin
          exp_x = exp_x + 1;
        end
      end
      chk("tog_x", 32'(vif_s.o_display_x_pos), 32'(exp_x));
      chk("tog_y", 32'(vif_s.o_display_y_pos), 32'(exp_y));
      if (vif_s.o_frame_start && !prev_fs) period = t;
      prev_fs = vif_s.o_frame_start;
    end
    chk("tog_period", 32'(period), 270);

    // Run into hsync and vsync, then reset for one cycle
    set_en(1'b1);
    reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      tick();
      if (vif_s.o_display_x_pos == 10'd11 && vif_s.o_display_y_pos == 10'd6) reached = 1'b1;
    end
    chk("mid_reached", 32'(reached), 1);
    chk("mid_hs", 32'(vif_s.o_hSync), 0);
    chk("mid_vs", 32'(vif_s.o_vSync), 0);
    rst = 1'b1;
    set_en(1'b0);
    tick();
    chk("mid_rst_x",  32'(vif_s.o_display_x_pos), 0);
    chk("mid_rst_y",  32'(vif_s.o_display_y_pos), 0);
    chk("mid_rst_hs", 32'(vif_s.o_hSync), 1);
    chk("mid_rst_vs", 32'(vif_s.o_vSync), 1);
    chk("mid_rst_act", 32'(vif_s.o_active), 0);
    rst = 1'b0;
    set_en(1'b1);
    tick();
    chk("rel_x",  32'(vif_s.o_display_x_pos), 0);
    chk("rel_y",  32'(vif_s.o_display_y_pos), 0);
    chk("rel_act", 32'(vif_s.o_active), 1);
    chk("rel_fs", 32'(vif_s.o_frame_start), 1);
    chk("rel_ls", 32'(vif_s.o_line_start), 1);
    tick();
    chk("rel_next_x", 32'(vif_s.o_display_x_pos), 1);
    chk("rel_next_fs", 32'(vif_s.o_frame_start), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 i_CLK  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-010 i_RST  input  1  reset, synchronous and active-high.
REQ-011 i_pix_en  input  1  pixel-advance enable; timing advances only on cycles where it is 1.
REQ-012 o_hSync  output  1  horizontal sync, active-low.
REQ-013 o_vSync  output  1  vertical sync, active-low.
REQ-014 o_display_x_pos  output  10  horizontal count, 0..H_TOTAL-1; values >= H_ACTIVE are blanking.
REQ-015 o_display_y_pos  output  10  vertical count, 0..V_TOTAL-1; values >= V_ACTIVE are blanking.
REQ-016 o_active  output  1  high when x < H_ACTIVE and y < V_ACTIVE.
REQ-017 o_frame_start  output  1  one-cycle pulse when the counters enter (0,0).
REQ-018 o_line_start  output  1  one-cycle pulse when x enters 0.

Function
REQ-019 The block SHALL define H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (default 800) and V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (default 525).
REQ-020 Each axis SHALL run a four-state FSM, ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with a per-state 10-bit segment counter.
REQ-021 Each state SHALL last exactly its parameter length; a transition occurs when the segment counter reaches length-1.
REQ-022 The horizontal axis SHALL advance one pixel per cycle with i_pix_en = 1, and SHALL hold all state, counters and outputs when i_pix_en = 0.
REQ-023 The vertical axis SHALL advance exactly once per line, on the cycle where x wraps from H_TOTAL-1 to 0.
REQ-024 x SHALL wrap from H_TOTAL-1 to 0, and y SHALL wrap from V_TOTAL-1 to 0 only when x also wraps.
REQ-025 o_hSync SHALL be 0 exactly while the horizontal FSM is in SYNC (x = 656..751 by default), and 1 otherwise.
REQ-026 o_vSync SHALL be 0 exactly while the vertical FSM is in SYNC (y = 490..491 by default), and 1 otherwise.
REQ-027 All outputs SHALL be registered and mutually aligned: sync levels, positions, o_active and the start pulses on any cycle describe the same pixel.
REQ-028 o_line_start SHALL be 1 for one enabled cycle when x = 0; o_frame_start SHALL additionally require y = 0.
REQ-029 Position outputs SHALL be zero-extended to 10 bits; parameter totals above 1024 are illegal and flagged by an elaboration-time check.

Reset
REQ-030 While i_RST = 1, both FSMs SHALL be in ACTIVE and x = 0, y = 0.
REQ-031 While i_RST = 1, o_hSync = 1, o_vSync = 1, o_active = 0, o_frame_start = 0 and o_line_start = 0.
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge regardless of i_pix_en.
REQ-033 On the first enabled cycle after release, the outputs SHALL present (0,0) with o_active = 1 and both start pulses = 1.

Structure
REQ-034 Default timing constants and the axis-state enum (ACTIVE, FRONT, SYNC, BACK) SHALL reside in the shared package vga_pkg.
REQ-035 The per-axis FSM and counter SHALL be one sub-module, vga_axis_timer, instantiated twice: once with the H parameters (step = i_pix_en) and once with the V parameters (step = horizontal wrap).

Verification
REQ-036 Release reset with i_pix_en = 1 and run 800 cycles -> o_hSync low for exactly 96 cycles starting at x = 656; o_line_start pulses again at cycle 800.
REQ-037 Run one full frame (420000 cycles) -> exactly one o_frame_start; o_vSync low for exactly 1600 cycles, beginning at y = 490, x = 0.
REQ-038 Count o_active over one frame -> exactly 307200 high cycles.
REQ-039 Toggle i_pix_en 1/0 every cycle -> frame period doubles to 840000 cycles; outputs hold unchanged on disabled cycles.
REQ-040 Assert i_RST at x = 700, y = 491 for one cycle -> the next cycle shows x = 0, y = 0, o_hSync = 1 and o_vSync = 1.
REQ-041 Check the boundary at x = 799, y = 524 -> the next enabled cycle shows x = 0, y = 0 and o_frame_start = 1.
